pt_derivative_mc: RTL and testbench



---
 rtl/pt_pkg.sv | 31 +++
 rtl/pt_deriv_hist.sv | 58 +++++
 rtl/pt_derivative_mc.sv | 129 ++++++++++++
 tb/tb_pt_derivative_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the Pan-Tompkins pipeline stages: mode codes,
// default sample width and a signed saturating width reduction.
package pt_pkg;

  localparam int unsigned PT_DATA_WIDTH = 11;

  localparam logic DERIV_DIFF = 1'b0;
  localparam logic DERIV_PT5  = 1'b1;

  // Clamp v into ow-bit signed range; returns {clipped, clamped value}.
  function automatic logic [32:0] saturate(input logic signed [31:0] v,
                                           input int unsigned        ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic        [31:0] val;
    logic               sat;
    hi  = (32'sd1 <<< (ow - 32'd1)) - 32'sd1;
    lo  = -(32'sd1 <<< (ow - 32'd1));
    val = v;
    sat = 1'b0;
    if (v > hi) begin
      val = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      val = lo;
      sat = 1'b1;
    end
    return {sat, val};
  endfunction

endpackage

// File: rtl/pt_deriv_hist.sv
// Per-channel 4-deep sample history with saturating warm-up counter.
// Shift on write, clear on flush, combinational read for the addressed channel.
module pt_deriv_hist
  import pt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PT_DATA_WIDTH,
  parameter int unsigned CH_W       = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_wr,
  input  logic                  i_clr,
  input  logic [CH_W-1:0]       i_ch,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_x1,
  output logic [DATA_WIDTH-1:0] o_x3,
  output logic [DATA_WIDTH-1:0] o_x4,
  output logic [2:0]            o_cnt
);

  localparam int unsigned CH_SPAN = 1 << CH_W;

  logic [DATA_WIDTH-1:0] r_x1  [CH_SPAN];
  logic [DATA_WIDTH-1:0] r_x2  [CH_SPAN];
  logic [DATA_WIDTH-1:0] r_x3  [CH_SPAN];
  logic [DATA_WIDTH-1:0] r_x4  [CH_SPAN];
  logic [2:0]            r_cnt [CH_SPAN];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < CH_SPAN; i++) begin
        r_x1[CH_W'(i)]  <= '0;
        r_x2[CH_W'(i)]  <= '0;
        r_x3[CH_W'(i)]  <= '0;
        r_x4[CH_W'(i)]  <= '0;
        r_cnt[CH_W'(i)] <= '0;
      end
    end else if (i_clr) begin
      r_x1[i_ch]  <= '0;
      r_x2[i_ch]  <= '0;
      r_x3[i_ch]  <= '0;
      r_x4[i_ch]  <= '0;
      r_cnt[i_ch] <= '0;
    end else if (i_wr) begin
      r_x4[i_ch] <= r_x3[i_ch];
      r_x3[i_ch] <= r_x2[i_ch];
      r_x2[i_ch] <= r_x1[i_ch];
      r_x1[i_ch] <= i_data;
      if (r_cnt[i_ch] != 3'd4) r_cnt[i_ch] <= r_cnt[i_ch] + 3'd1;
    end
  end

  assign o_x1  = r_x1[i_ch];
  assign o_x3  = r_x3[i_ch];
  assign o_x4  = r_x4[i_ch];
  assign o_cnt = r_cnt[i_ch];

endmodule

// File: rtl/pt_derivative_mc.sv
// Multi-channel derivative stage: first difference or 5-point Pan-Tompkins
// derivative, two-stage pipeline with warm-up qualification and saturation.
module pt_derivative_mc
  import pt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PT_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH + 1,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned SHIFT      = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_in_valid,
  input  logic [CH_W-1:0]       i_in_ch,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_mode,
  input  logic                  i_flush,
  output logic                  o_out_valid,
  output logic [CH_W-1:0]       o_out_ch,
  output logic [OUT_WIDTH-1:0]  o_out_data,
  output logic                  o_out_primed,
  output logic                  o_out_sat
);

  localparam int unsigned RW      = DATA_WIDTH + 4;
  localparam int unsigned CH_SPAN = 1 << CH_W;
  localparam logic [CH_SPAN-1:0] CH_MASK = {CH_SPAN{1'b1}} >> (CH_SPAN - NUM_CH);

  logic                  w_ch_ok;
  logic                  w_wr;
  logic                  w_clr;
  logic [DATA_WIDTH-1:0] w_x1;
  logic [DATA_WIDTH-1:0] w_x3;
  logic [DATA_WIDTH-1:0] w_x4;
  logic [2:0]            w_cnt;
  logic signed [RW-1:0]  w_e0;
  logic signed [RW-1:0]  w_e1;
  logic signed [RW-1:0]  w_e3;
  logic signed [RW-1:0]  w_e4;
  logic signed [RW-1:0]  w_raw;
  logic                  w_primed;
  logic signed [RW-1:0]  w_shifted;
  logic signed [31:0]    w_shift32;
  logic [OUT_WIDTH-1:0]  w_out;
  logic                  w_sat;

  logic                  r_s1_valid;
  logic signed [RW-1:0]  r_s1_raw;
  logic [CH_W-1:0]       r_s1_ch;
  logic                  r_s1_mode;
  logic                  r_s1_primed;

  // Channel IDs outside the configured range are silently dropped.
  assign w_ch_ok = CH_MASK[i_in_ch];
  assign w_clr   = i_flush & w_ch_ok;
  assign w_wr    = i_in_valid & ~i_flush & w_ch_ok;

  pt_deriv_hist #(
    .DATA_WIDTH (DATA_WIDTH),
    .CH_W       (CH_W)
  ) u_hist (
    .clk    (clk),
    .rstn   (rstn),
    .i_wr   (w_wr),
    .i_clr  (w_clr),
    .i_ch   (i_in_ch),
    .i_data (i_in_data),
    .o_x1   (w_x1),
    .o_x3   (w_x3),
    .o_x4   (w_x4),
    .o_cnt  (w_cnt)
  );

  assign w_e0 = RW'($signed(i_in_data));
  assign w_e1 = RW'($signed(w_x1));
  assign w_e3 = RW'($signed(w_x3));
  assign w_e4 = RW'($signed(w_x4));

  always_comb begin
    w_raw    = w_e0 - w_e1;
    w_primed = (w_cnt != 3'd0);
    if (i_mode == DERIV_PT5) begin
      w_raw    = (w_e0 <<< 1) + w_e1 - w_e3 - (w_e4 <<< 1);
      w_primed = (w_cnt == 3'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= '0;
      r_s1_ch     <= '0;
      r_s1_mode   <= 1'b0;
      r_s1_primed <= 1'b0;
    end else begin
      r_s1_valid <= w_wr;
      if (w_wr) begin
        r_s1_raw    <= w_raw;
        r_s1_ch     <= i_in_ch;
        r_s1_mode   <= i_mode;
        r_s1_primed <= w_primed;
      end
    end
  end

  // Floor scaling applies only to the 5-point result.
  assign w_shifted = (r_s1_mode == DERIV_PT5) ? (r_s1_raw >>> SHIFT) : r_s1_raw;
  assign w_shift32 = 32'(w_shifted);
  assign w_out     = OUT_WIDTH'(saturate(w_shift32, OUT_WIDTH));
  assign w_sat     = 1'(saturate(w_shift32, OUT_WIDTH) >> 32);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_out_valid  <= 1'b0;
      o_out_ch     <= '0;
      o_out_data   <= '0;
      o_out_primed <= 1'b0;
      o_out_sat    <= 1'b0;
    end else begin
      o_out_valid  <= r_s1_valid;
      o_out_ch     <= r_s1_ch;
      o_out_data   <= w_out;
      o_out_primed <= r_s1_primed;
      o_out_sat    <= w_sat;
    end
  end

endmodule

// File: tb/tb_pt_derivative_mc.sv
// Bench for pt_derivative_mc: a default instance and a narrow-output,
// three-channel instance driven in parallel against an arithmetic model.
module tb_pt_derivative_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [10:0] in_data;
  logic        mode;
  logic        flush;

  logic        a_valid;
  logic [0:0]  a_ch;
  logic [11:0] a_data;
  logic        a_primed;
  logic        a_sat;

  logic        b_valid;
  logic [1:0]  b_ch;
  logic [10:0] b_data;
  logic        b_primed;
  logic        b_sat;

  always #5 clk = ~clk;

  pt_derivative_mc u_a (
    .clk          (clk),
    .rstn         (rstn),
    .i_in_valid   (in_valid),
    .i_in_ch      (in_ch[0]),
    .i_in_data    (in_data),
    .i_mode       (mode),
    .i_flush      (flush),
    .o_out_valid  (a_valid),
    .o_out_ch     (a_ch),
    .o_out_data   (a_data),
    .o_out_primed (a_primed),
    .o_out_sat    (a_sat)
  );

  pt_derivative_mc #(.OUT_WIDTH(11), .NUM_CH(3)) u_b (
    .clk          (clk),
    .rstn         (rstn),
    .i_in_valid   (in_valid),
    .i_in_ch      (in_ch),
    .i_in_data    (in_data),
    .i_mode       (mode),
    .i_flush      (flush),
    .o_out_valid  (b_valid),
    .o_out_ch     (b_ch),
    .o_out_data   (b_data),
    .o_out_primed (b_primed),
    .o_out_sat    (b_sat)
  );

  typedef struct {
    int due;
    int ch;
    int data;
    bit primed;
    bit sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   hist[2][4][4];
  int   cnt[2][4];
  int   got_a[$];
  int   got_b[$];
  int   gsat_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int r, input int d);
    int q;
    q = r / d;
    if ((r % d != 0) && (r < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        cnt[d][c] = 0;
        for (int k = 0; k < 4; k++) hist[d][c][k] = 0;
      end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_edge(input bit v, input int c_in, input int data, input bit m, input bit f);
    for (int d = 0; d < 2; d++) begin
      int c, nch, ow, lim, r, val;
      exp_t e;
      c   = (d == 0) ? (c_in % 2) : c_in;
      nch = (d == 0) ? 2 : 3;
      ow  = (d == 0) ? 12 : 11;
      if (c >= nch) continue;
      if (f) begin
        cnt[d][c] = 0;
        for (int k = 0; k < 4; k++) hist[d][c][k] = 0;
        continue;
      end
      if (!v) continue;
      if (m) begin
        r   = 2 * data + hist[d][c][0] - hist[d][c][2] - 2 * hist[d][c][3];
        val = floor_div(r, 8);
        e.primed = (cnt[d][c] >= 4);
      end else begin
        val = data - hist[d][c][0];
        e.primed = (cnt[d][c] >= 1);
      end
      lim = 1 << (ow - 1);
      e.sat = 1'b0;
      if (val > lim - 1) begin val = lim - 1; e.sat = 1'b1; end
      if (val < -lim)    begin val = -lim;    e.sat = 1'b1; end
      e.data = val;
      e.ch   = c;
      e.due  = cyc + 1;
      if (d == 0) q_a.push_back(e); else q_b.push_back(e);
      for (int k = 3; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
      hist[d][c][0] = data;
      if (cnt[d][c] < 4) cnt[d][c]++;
    end
  endtask

  task automatic check_outputs(input bit in_reset);
    exp_t e;
    if (in_reset) begin
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_data", $signed(a_data), 0);
      chk("rst_a_ch", a_ch, 0);
      chk("rst_a_primed", a_primed, 0);
      chk("rst_a_sat", a_sat, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_data", $signed(b_data), 0);
      chk("rst_b_sat", b_sat, 0);
      return;
    end
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      e = q_a.pop_front();
      chk("a_valid", a_valid, 1);
      chk("a_ch", a_ch, e.ch);
      chk("a_data", $signed(a_data), e.data);
      chk("a_primed", a_primed, e.primed);
      chk("a_sat", a_sat, e.sat);
      got_a.push_back($signed(a_data));
    end else chk("a_idle", a_valid, 0);
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      e = q_b.pop_front();
      chk("b_valid", b_valid, 1);
      chk("b_ch", b_ch, e.ch);
      chk("b_data", $signed(b_data), e.data);
      chk("b_primed", b_primed, e.primed);
      chk("b_sat", b_sat, e.sat);
      got_b.push_back($signed(b_data));
      gsat_b.push_back(b_sat);
    end else chk("b_idle", b_valid, 0);
  endtask

  task automatic step(input bit v, input int c, input int data, input bit m, input bit f, input bit r);
    in_valid = v;
    in_ch    = 2'(c);
    in_data  = 11'(data);
    mode     = m;
    flush    = f;
    rstn     = r;
    @(posedge clk);
    cyc++;
    if (!r) model_reset(); else model_edge(v, c, data, m, f);
    #1;
    check_outputs(!r);
  endtask

  function automatic int last_of(input int q[$]);
    if (q.size() == 0) return -99999;
    return q[q.size()-1];
  endfunction

  initial begin
    int exp1[5];
    int n0;
    exp1 = '{200, 300, 300, 200, 0};
    model_reset();

    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 123, 1, 1, 0);

    // Step response, 5-point mode
    got_a.delete();
    for (int i = 0; i < 9; i++) step(1, 0, (i < 4) ? 0 : 800, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("step_count", got_a.size(), 9);
    for (int i = 0; i < 5; i++)
      if (got_a.size() == 9) chk("step_value", got_a[4+i], exp1[i]);

    // Ramps
    step(0, 0, 0, 0, 1, 1);
    for (int n = 0; n < 10; n++) step(1, 0, 8 * n, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ramp_up_last", last_of(got_a), 10);
    step(0, 0, 0, 0, 1, 1);
    for (int n = 0; n < 10; n++) step(1, 0, -n, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ramp_dn_last", last_of(got_a), -2);

    // Difference extremes: clipped on the narrow instance only
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, -1024, 0, 0, 1);
    step(1, 0, 1023, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("diff_wide", last_of(got_a), 2047);
    chk("diff_narrow", last_of(got_b), 1023);
    chk("diff_narrow_sat", last_of(gsat_b), 1);

    // Interleaved channels
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, (i < 4) ? 0 : 400, 1, 0, 1);
      step(1, 1, 100, 1, 0, 1);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n0 = got_a.size();
    chk("ilv_ch1_last", last_of(got_a), 0);
    if (n0 >= 2) chk("ilv_ch0_last", got_a[n0-2], 0);

    // Flush ch1 only
    step(0, 1, 0, 0, 1, 1);
    step(1, 1, 50, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_ch1", last_of(got_a), 50);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_ch0_kept", last_of(got_a), -400);

    // Reset with samples in flight
    step(1, 0, 5, 1, 0, 1);
    step(1, 1, 7, 1, 0, 1);
    step(1, 0, 300, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 33, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Random traffic, including out-of-range channels on the 3-channel instance
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2047)) - 1024, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
